bcd_counter_7seg_mux: RTL and testbench
=======================================

// Module: bcd_counter_7seg_mux
// PURPOSE
//  Multi-digit BCD up/down event counter with sampled press-edge detection and a
//  time-multiplexed common-anode 7-segment display driver. Generalises the single-digit
//  button counter to NDIG digits, two buttons (up/down) and scanned digit selects.
//  Sits between board push-buttons and the 7-seg connector (seg, K) in the top level.
// PARAMETERS
//  NDIG      4       number of BCD digits / digit-select lines (1..8)
//  TICK_DIV  250000  CLK cycles per button sample tick (>=2)
//  SCAN_DIV  50000   CLK cycles per display digit slot (>=2)
// PORTS
//  CLK     in   1       system clock, all logic on posedge
//  RST     in   1       synchronous reset, active-high
//  BTN_UP  in   1       raw up button, active-high, asynchronous to CLK
//  BTN_DN  in   1       raw down button, active-high, asynchronous to CLK
//  seg     out  7       segments {g,f,e,d,c,b,a}, active-low, registered
//  K       out  NDIG    digit selects, one-hot active-low, registered; K[0] = least significant digit
// BEHAVIOUR
//  Reset (RST=1 at posedge): tick_cnt=0, scan_cnt=0, scan_idx=0, all digits=0,
//   button history=0, K=~1 (digit 0 on), seg=7'b1000000 ("0"). RST overrides all else.
//  Sync: BTN_UP/BTN_DN each pass a 2-FF synchroniser (runs every cycle).
//  Tick: tick_cnt counts 0..TICK_DIV-1, wraps; tick=1 for one cycle when tick_cnt==TICK_DIV-1.
//  On tick: cur=synced level, prev<=cur; press_x = cur & ~prev (rising edge between ticks).
//   Holding a button yields exactly one press; bounce shorter than one tick period is ignored.
//  Count update, cycle after tick (digits change at tick+1):
//   up only  : BCD increment, digit i increments when all lower digits ==9; 9 -> 0 with carry.
//   dn only  : BCD decrement, digit i decrements when all lower digits ==0; 0 -> 9 with borrow.
//   both     : no change. neither: no change.
//   Wrap: all-9s +1 -> all-0s; all-0s -1 -> all-9s. Digits never leave 0..9.
//  Scan: scan_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 scan_idx <= (scan_idx==NDIG-1)?0:scan_idx+1.
//   K/seg are registered from scan_idx and digit[scan_idx]: outputs lag by one cycle;
//   K is always exactly one-hot low (no all-off gaps, no two-hot).
//  Decode (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; any other code -> 1111111 (blank).
//  Counter update and scan are independent; a count change on the displayed digit shows
//   on seg one cycle after the digit register changes, no scan restart.
//  Reset mid-press: history cleared to 0, so a button still held after RST release is
//   counted once at the first tick that samples it high.
//  Widths: tick/scan counters sized $clog2(DIV); scan_idx $clog2(NDIG) (min 1 bit).
// TESTING  (bench params NDIG=4, TICK_DIV=4, SCAN_DIV=3)
//  1 RST 2 cycles -> K=4'b1110, seg=7'b1000000, all digits 0; scan K 1110,1101,1011,0111,1110 every 3 cycles.
//  2 Hold BTN_UP 40 cycles from 0000 -> count 0001 only; release, 12 presses -> digits read 0013.
//  3 Preload 0999 via presses, one BTN_UP press -> 1000 (carry ripple); from 9999 +1 -> 0000.
//  4 From 0000 one BTN_DN press -> 9999; from 1000 -1 -> 0999.
//  5 BTN_UP and BTN_DN rise together -> count unchanged; 1-cycle glitch between ticks -> no count.
//  6 RST while BTN_UP held at 0042 -> 0000, then exactly one increment to 0001 after RST release.

Source files
------------

// File: rtl/bcd_counter_7seg_mux.sv
// Multi-digit BCD up/down event counter fed by sampled, edge-detected push-buttons,
// driving a scanned common-anode 7-segment display (active-low segments and selects).
module bcd_counter_7seg_mux #(
   parameter int NDIG     = 4,
   parameter int TICK_DIV = 250000,
   parameter int SCAN_DIV = 50000
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            BTN_UP,
   input  logic            BTN_DN,
   output logic [6:0]      seg,
   output logic [NDIG-1:0] K
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

   logic          up_meta, up_sync, dn_meta, dn_sync;
   logic          up_prev, dn_prev;
   logic          press_up, press_dn;
   logic          tick;
   logic          carry;
   logic [TW-1:0] tick_cnt;
   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] scan_idx;
   logic [3:0]    digits      [NDIG];
   logic [3:0]    digits_next [NDIG];

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b1111111;
      endcase
   endfunction

   assign tick = (tick_cnt == TICK_LAST);

   // Ripple the carry/borrow from digit 0 upward; a single press never moves more than one step.
   always_comb begin
      carry = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         digits_next[i] = digits[i];
      end
      if (press_up && !press_dn) begin
         for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
               if (digits[i] >= 4'd9) begin
                  digits_next[i] = 4'd0;
               end else begin
                  digits_next[i] = digits[i] + 4'd1;
                  carry          = 1'b0;
               end
            end
         end
      end else if (press_dn && !press_up) begin
         for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
               if (digits[i] == 4'd0 || digits[i] > 4'd9) begin
                  digits_next[i] = 4'd9;
               end else begin
                  digits_next[i] = digits[i] - 4'd1;
                  carry          = 1'b0;
               end
            end
         end
      end
   end

   // Buttons are only looked at on tick, so bounce shorter than a tick period never registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         up_meta  <= 1'b0;
         up_sync  <= 1'b0;
         dn_meta  <= 1'b0;
         dn_sync  <= 1'b0;
         up_prev  <= 1'b0;
         dn_prev  <= 1'b0;
         press_up <= 1'b0;
         press_dn <= 1'b0;
         tick_cnt <= '0;
         for (int i = 0; i < NDIG; i++) begin
            digits[i] <= 4'd0;
         end
      end else begin
         up_meta  <= BTN_UP;
         up_sync  <= up_meta;
         dn_meta  <= BTN_DN;
         dn_sync  <= dn_meta;
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         if (tick) begin
            up_prev <= up_sync;
            dn_prev <= dn_sync;
         end
         press_up <= tick & up_sync & ~up_prev;
         press_dn <= tick & dn_sync & ~dn_prev;
         for (int i = 0; i < NDIG; i++) begin
            digits[i] <= digits_next[i];
         end
      end
   end

   // Display scan runs freely; outputs are registered so K always holds exactly one low bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         scan_cnt <= '0;
         scan_idx <= '0;
         K        <= ~NDIG'(1);
         seg      <= 7'b1000000;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         K   <= ~(NDIG'(1) << scan_idx);
         seg <= decode(digits[scan_idx]);
      end
   end

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Directed bench for bcd_counter_7seg_mux: counts are read back through the scanned
// display and compared against hand-computed decimal values.
module tb_bcd_counter_7seg_mux;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       BTN_UP = 1'b0;
   logic       BTN_DN = 1'b0;
   logic [6:0] seg;
   logic [3:0] K;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int rel        = 0;
   logic [6:0] disp [4];

   bcd_counter_7seg_mux #(.NDIG(4), .TICK_DIV(4), .SCAN_DIV(3)) dut (
      .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .seg(seg), .K(K)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [6:0] enc(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int digit_of(input int v, input int i);
      int p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      return (v / p) % 10;
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      rel = cyc;
   endtask

   task automatic press(input logic up, input logic dn);
      @(negedge CLK);
      BTN_UP = up;
      BTN_DN = dn;
      repeat (6) @(negedge CLK);
      BTN_UP = 1'b0;
      BTN_DN = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   task automatic read_display();
      for (int i = 0; i < 4; i++) disp[i] = 'x;
      repeat (14) begin
         @(negedge CLK);
         case (K)
            4'b1110: disp[0] = seg;
            4'b1101: disp[1] = seg;
            4'b1011: disp[2] = seg;
            4'b0111: disp[3] = seg;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      logic [3:0] k_exp [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      @(negedge CLK);
      BTN_UP = 1'b0;
      BTN_DN = 1'b0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      compared++;
      if (K !== 4'b1110) begin
         mismatched++;
         $display("[TB] FAIL reset_K: got %b want %b", K, 4'b1110);
      end
      compared++;
      if (seg !== 7'b1000000) begin
         mismatched++;
         $display("[TB] FAIL reset_seg: got %b want %b", seg, 7'b1000000);
      end
      RST = 1'b0;
      rel = cyc;
      for (int s = 0; s < 5; s++) begin
         while (cyc != rel + 2 + 3 * s) @(negedge CLK);
         compared++;
         if (K !== k_exp[s]) begin
            mismatched++;
            $display("[TB] FAIL scan_K slot%0d: got %b want %b", s, K, k_exp[s]);
         end
         compared++;
         if (seg !== 7'b1000000) begin
            mismatched++;
            $display("[TB] FAIL scan_seg slot%0d: got %b want %b", s, seg, 7'b1000000);
         end
      end
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(0)) begin
            mismatched++;
            $display("[TB] FAIL reset_digit%0d: got %b want %b", i, disp[i], enc(0));
         end
      end
   endtask

   task automatic test_hold_and_presses();
      @(negedge CLK);
      BTN_UP = 1'b1;
      repeat (40) @(negedge CLK);
      BTN_UP = 1'b0;
      repeat (10) @(negedge CLK);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(1, i))) begin
            mismatched++;
            $display("[TB] FAIL hold_once digit%0d: got %b want %b", i, disp[i], enc(digit_of(1, i)));
         end
      end
      repeat (12) press(1'b1, 1'b0);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(13, i))) begin
            mismatched++;
            $display("[TB] FAIL twelve_presses digit%0d: got %b want %b", i, disp[i], enc(digit_of(13, i)));
         end
      end
   endtask

   task automatic test_carry_borrow();
      int steps [3] = '{443, 333, 210};
      int vals  [3] = '{456, 789, 999};
      for (int s = 0; s < 3; s++) begin
         repeat (steps[s]) press(1'b1, 1'b0);
         read_display();
         for (int i = 0; i < 4; i++) begin
            compared++;
            if (disp[i] !== enc(digit_of(vals[s], i))) begin
               mismatched++;
               $display("[TB] FAIL preload_%0d digit%0d: got %b want %b", vals[s], i, disp[i], enc(digit_of(vals[s], i)));
            end
         end
      end
      press(1'b1, 1'b0);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(1000, i))) begin
            mismatched++;
            $display("[TB] FAIL carry_ripple digit%0d: got %b want %b", i, disp[i], enc(digit_of(1000, i)));
         end
      end
      press(1'b0, 1'b1);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(999, i))) begin
            mismatched++;
            $display("[TB] FAIL borrow_ripple digit%0d: got %b want %b", i, disp[i], enc(digit_of(999, i)));
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      press(1'b0, 1'b1);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(9)) begin
            mismatched++;
            $display("[TB] FAIL wrap_down digit%0d: got %b want %b", i, disp[i], enc(9));
         end
      end
      press(1'b1, 1'b0);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(0)) begin
            mismatched++;
            $display("[TB] FAIL wrap_up digit%0d: got %b want %b", i, disp[i], enc(0));
         end
      end
   endtask

   task automatic test_both_and_glitch();
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(1, i))) begin
            mismatched++;
            $display("[TB] FAIL both_buttons digit%0d: got %b want %b", i, disp[i], enc(digit_of(1, i)));
         end
      end
      // Glitches land on an edge two cycles away from any button sampling point.
      @(negedge CLK);
      while (((cyc + 1 - rel) % 4) != 0) @(negedge CLK);
      BTN_UP = 1'b1;
      @(negedge CLK);
      BTN_UP = 1'b0;
      repeat (7) @(negedge CLK);
      while (((cyc + 1 - rel) % 4) != 0) @(negedge CLK);
      BTN_DN = 1'b1;
      @(negedge CLK);
      BTN_DN = 1'b0;
      repeat (12) @(negedge CLK);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(1, i))) begin
            mismatched++;
            $display("[TB] FAIL glitch digit%0d: got %b want %b", i, disp[i], enc(digit_of(1, i)));
         end
      end
   endtask

   task automatic test_reset_mid_press();
      repeat (41) press(1'b1, 1'b0);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(42, i))) begin
            mismatched++;
            $display("[TB] FAIL preload_42 digit%0d: got %b want %b", i, disp[i], enc(digit_of(42, i)));
         end
      end
      @(negedge CLK);
      BTN_UP = 1'b1;
      repeat (10) @(negedge CLK);
      do_reset();
      repeat (30) @(negedge CLK);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(1, i))) begin
            mismatched++;
            $display("[TB] FAIL held_after_reset digit%0d: got %b want %b", i, disp[i], enc(digit_of(1, i)));
         end
      end
      BTN_UP = 1'b0;
      repeat (12) @(negedge CLK);
      read_display();
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (disp[i] !== enc(digit_of(1, i))) begin
            mismatched++;
            $display("[TB] FAIL release_after_reset digit%0d: got %b want %b", i, disp[i], enc(digit_of(1, i)));
         end
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_hold_and_presses();
      test_carry_borrow();
      test_wrap();
      test_both_and_glitch();
      test_reset_mid_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
